// File: rtl/paula_diskdma_pkg.sv
// Shared definitions for the Paula disk DMA sequencer: register addresses,
// DSKLEN field layout, FIFO geometry and the sequencer state encoding.
package paula_diskdma_pkg;

   localparam logic [8:0] DSKLEN  = 9'h024;
   localparam logic [8:0] DSKDAT  = 9'h026;
   localparam logic [8:0] DSKDATR = 9'h008;

   localparam int DSKLEN_LEN_MSB = 13;
   localparam int DSKLEN_WR_BIT  = 14;
   localparam int DSKLEN_EN_BIT  = 15;

   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
   localparam logic [2:0]         LEVEL_FULL = 3'(FIFO_DEPTH);
   localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARMED     = 3'd1,
      ST_WAIT_SYNC = 3'd2,
      ST_READ      = 3'd3,
      ST_WRITE     = 3'd4,
      ST_DONE      = 3'd5
   } dsk_state_t;

   // The bus carries word addresses [8:1]; compare against a byte register address.
   function automatic logic addr_hit(input logic [7:0] addr, input logic [8:0] reg_byte);
      return addr == reg_byte[8:1];
   endfunction

endpackage

// File: rtl/paula_diskdma_fifo.sv
// 4x16 word FIFO between the MFM shifter and the chip bus. Push and pop may
// occur in the same cycle; push is refused when full, pop when empty.
module paula_diskdma_fifo
   import paula_diskdma_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk7_en,
   input  logic        flush,
   input  logic        push,
   input  logic        pop,
   input  logic [15:0] din,
   output logic [15:0] dout,
   output logic        full,
   output logic        empty,
   output logic [2:0]  level
);

   logic [15:0]        mem_r [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wptr_r;
   logic [FIFO_AW-1:0] rptr_r;
   logic [2:0]         level_r;
   logic               push_s;
   logic               pop_s;

   assign full   = (level_r == LEVEL_FULL);
   assign empty  = (level_r == 3'd0);
   assign level  = level_r;
   assign dout   = mem_r[rptr_r];
   assign push_s = clk7_en & push & ~full & ~flush;
   assign pop_s  = clk7_en & pop & ~empty & ~flush;

   // Pointer and occupancy tracking; a flush overrides any same-cycle push or pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         level_r <= 3'd0;
      end else if (clk7_en && flush) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         level_r <= 3'd0;
      end else begin
         if (push_s) begin
            wptr_r <= wptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rptr_r <= rptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + 3'd1;
            2'b01:   level_r <= level_r - 3'd1;
            default: level_r <= level_r;
         endcase
      end
   end

   // Word storage; contents are don't-care while empty, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wptr_r] <= din;
      end
   end

endmodule

// File: rtl/paula_diskdma_ctl.sv
// Paula disk DMA sequencer: decodes DSKLEN, tracks the remaining word count,
// requests DMA slots from Agnus and moves words through the 4-word FIFO.
module paula_diskdma_ctl
   import paula_diskdma_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk7_en,
   input  logic [7:0]  reg_address_in,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   input  logic        dmaen,
   input  logic        wordsync,
   input  logic        sync_match,
   input  logic        sh_push,
   input  logic [15:0] sh_word,
   input  logic        sh_pull,
   output logic [15:0] sh_dout,
   output logic        dmal,
   output logic        dmas,
   output logic        int_dskblk,
   output logic        busy,
   output logic        overrun,
   output logic        underrun
);

   dsk_state_t  state_r;
   logic [13:0] len_r;
   logic [13:0] count_r;
   logic [13:0] push_left_r;
   logic        wr_r;
   logic        dmas_r;
   logic        overrun_r;
   logic        underrun_r;
   logic [15:0] sh_dout_r;

   logic        dsklen_wr_s;
   logic        rd_grant_s;
   logic        wr_grant_s;
   logic        sh_push_ok_s;
   logic        sh_pull_ok_s;
   logic        wr_done_s;
   logic        count_nz_s;
   logic        fifo_flush_s;
   logic        fifo_push_s;
   logic        fifo_pop_s;
   logic [15:0] fifo_din_s;
   logic [15:0] fifo_head_s;
   logic        fifo_full_s;
   logic        fifo_empty_s;
   logic [2:0]  fifo_level_s;

   assign count_nz_s   = (count_r != 14'd0);
   assign dsklen_wr_s  = clk7_en & addr_hit(reg_address_in, DSKLEN);
   assign rd_grant_s   = clk7_en & dmaen & (state_r == ST_READ)  & addr_hit(reg_address_in, DSKDATR);
   assign wr_grant_s   = clk7_en & dmaen & (state_r == ST_WRITE) & addr_hit(reg_address_in, DSKDAT);
   assign sh_push_ok_s = clk7_en & sh_push & (state_r == ST_READ) & (push_left_r != 14'd0);
   assign sh_pull_ok_s = clk7_en & sh_pull & (state_r == ST_WRITE);
   // The last pull empties the FIFO only if no bus word lands in the same cycle.
   assign wr_done_s    = sh_pull_ok_s & dmaen & ~count_nz_s & (fifo_level_s == 3'd1) & ~wr_grant_s;

   assign fifo_flush_s = (dsklen_wr_s & ~data_in[DSKLEN_EN_BIT]) | (state_r == ST_DONE);
   assign fifo_push_s  = (sh_push_ok_s | wr_grant_s) & ~fifo_full_s;
   assign fifo_pop_s   = rd_grant_s | sh_pull_ok_s;

   assign data_out   = (rd_grant_s && !fifo_empty_s) ? fifo_head_s : 16'h0000;
   assign sh_dout    = sh_dout_r;
   assign dmas       = dmas_r;
   assign busy       = (state_r != ST_IDLE) && (state_r != ST_ARMED);
   assign int_dskblk = (state_r == ST_DONE) & clk7_en;
   assign overrun    = overrun_r;
   assign underrun   = underrun_r;

   // FIFO write data: shifter words on the read path, bus words on the write path.
   always_comb begin
      fifo_din_s = 16'h0000;
      if (state_r == ST_WRITE) begin
         fifo_din_s = data_in;
      end else begin
         fifo_din_s = sh_word;
      end
   end

   // DMA request: read side needs data to hand over, write side needs room.
   always_comb begin
      dmal = 1'b0;
      case (state_r)
         ST_READ:  dmal = dmaen & ~fifo_empty_s & count_nz_s;
         ST_WRITE: dmal = dmaen & ~fifo_full_s & count_nz_s;
         default:  dmal = 1'b0;
      endcase
   end

   // Sequencer: DSKLEN decode, count tracking, completion and sticky error flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         len_r       <= 14'd0;
         count_r     <= 14'd0;
         push_left_r <= 14'd0;
         wr_r        <= 1'b0;
         dmas_r      <= 1'b0;
         overrun_r   <= 1'b0;
         underrun_r  <= 1'b0;
      end else if (clk7_en) begin
         if (dsklen_wr_s && !data_in[DSKLEN_EN_BIT]) begin
            state_r     <= ST_IDLE;
            count_r     <= 14'd0;
            push_left_r <= 14'd0;
            dmas_r      <= 1'b0;
            overrun_r   <= 1'b0;
            underrun_r  <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (dsklen_wr_s) begin
                     state_r <= ST_ARMED;
                     len_r   <= data_in[DSKLEN_LEN_MSB:0];
                     wr_r    <= data_in[DSKLEN_WR_BIT];
                  end
               end
               ST_ARMED: begin
                  if (dsklen_wr_s) begin
                     count_r     <= len_r;
                     push_left_r <= len_r;
                     dmas_r      <= wr_r;
                     if (len_r == 14'd0) begin
                        state_r <= ST_DONE;
                     end else if (wr_r) begin
                        state_r <= ST_WRITE;
                     end else if (wordsync) begin
                        state_r <= ST_WAIT_SYNC;
                     end else begin
                        state_r <= ST_READ;
                     end
                  end
               end
               ST_WAIT_SYNC: begin
                  if (sync_match && dmaen) begin
                     state_r <= ST_READ;
                  end
               end
               ST_READ: begin
                  if (sh_push_ok_s) begin
                     if (fifo_full_s) begin
                        overrun_r <= 1'b1;
                     end else begin
                        push_left_r <= push_left_r - 14'd1;
                     end
                  end
                  if (rd_grant_s && count_nz_s) begin
                     count_r <= count_r - 14'd1;
                     if (count_r == 14'd1) begin
                        state_r <= ST_DONE;
                     end
                  end
               end
               ST_WRITE: begin
                  if (sh_pull_ok_s && fifo_empty_s) begin
                     underrun_r <= 1'b1;
                  end
                  if (wr_grant_s && count_nz_s) begin
                     count_r <= count_r - 14'd1;
                  end
                  if (wr_done_s) begin
                     state_r <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  state_r <= ST_IDLE;
                  dmas_r  <= 1'b0;
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Write-path output word: FIFO head on each pull, fill pattern when starved.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_dout_r <= 16'h0000;
      end else if (sh_pull_ok_s) begin
         sh_dout_r <= fifo_empty_s ? 16'hAAAA : fifo_head_s;
      end
   end

   paula_diskdma_fifo u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clk7_en (clk7_en),
      .flush   (fifo_flush_s),
      .push    (fifo_push_s),
      .pop     (fifo_pop_s),
      .din     (fifo_din_s),
      .dout    (fifo_head_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .level   (fifo_level_s)
   );

endmodule

// File: tb/tb_paula_diskdma_ctl.sv
// Scoreboard bench for paula_diskdma_ctl: stimulus queues expected read words,
// write-path words and block interrupts; a monitor pops and compares them.
module tb_paula_diskdma_ctl;

   localparam logic [7:0] A_DSKLEN  = 8'h12;
   localparam logic [7:0] A_DSKDAT  = 8'h13;
   localparam logic [7:0] A_DSKDATR = 8'h04;
   localparam logic [7:0] A_NOP     = 8'hFF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clk7_en;
   logic [7:0]  reg_address_in;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        dmaen;
   logic        wordsync;
   logic        sync_match;
   logic        sh_push;
   logic [15:0] sh_word;
   logic        sh_pull;
   logic [15:0] sh_dout;
   logic        dmal;
   logic        dmas;
   logic        int_dskblk;
   logic        busy;
   logic        overrun;
   logic        underrun;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] exp_rd[$];
   logic [15:0] exp_wr[$];
   int          exp_blk[$];
   logic        pull_prev = 1'b0;
   logic [15:0] mon_e;
   int          mon_tag;

   paula_diskdma_ctl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .clk7_en        (clk7_en),
      .reg_address_in (reg_address_in),
      .data_in        (data_in),
      .data_out       (data_out),
      .dmaen          (dmaen),
      .wordsync       (wordsync),
      .sync_match     (sync_match),
      .sh_push        (sh_push),
      .sh_word        (sh_word),
      .sh_pull        (sh_pull),
      .sh_dout        (sh_dout),
      .dmal           (dmal),
      .dmas           (dmas),
      .int_dskblk     (int_dskblk),
      .busy           (busy),
      .overrun        (overrun),
      .underrun       (underrun)
   );

   always #5 clk = ~clk;

   // Monitor: compares DUT outputs against the scoreboard queues mid-cycle.
   always @(negedge clk) begin
      if (reset_n) begin
         if (clk7_en && reg_address_in == A_DSKDATR) begin
            n_vec++;
            if (exp_rd.size() == 0) begin
               n_err++;
               $display("FAIL rd_unexpected: data_out=%h, no read slot expected", data_out);
            end else begin
               mon_e = exp_rd.pop_front();
               if (data_out !== mon_e) begin
                  n_err++;
                  $display("FAIL rd_data: got %h, want %h", data_out, mon_e);
               end
            end
         end
         if (pull_prev) begin
            n_vec++;
            if (exp_wr.size() == 0) begin
               n_err++;
               $display("FAIL wr_unexpected: sh_dout=%h, no pull expected", sh_dout);
            end else begin
               mon_e = exp_wr.pop_front();
               if (sh_dout !== mon_e) begin
                  n_err++;
                  $display("FAIL wr_data: got %h, want %h", sh_dout, mon_e);
               end
            end
         end
         pull_prev = sh_pull;
         if (int_dskblk) begin
            n_vec++;
            if (exp_blk.size() == 0) begin
               n_err++;
               $display("FAIL blk_unexpected: int_dskblk=1, want 0");
            end else begin
               mon_tag = exp_blk.pop_front();
            end
         end
      end else begin
         pull_prev = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      reg_address_in = A_NOP;
      data_in        = 16'h0000;
      sh_push        = 1'b0;
      sh_word        = 16'h0000;
      sh_pull        = 1'b0;
      sync_match     = 1'b0;
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [15:0] d);
      reg_address_in = a;
      data_in        = d;
      tick();
      idle_bus();
   endtask

   task automatic push_word(input logic [15:0] w);
      sh_push = 1'b1;
      sh_word = w;
      tick();
      idle_bus();
   endtask

   task automatic grant_rd(input logic [15:0] expect_word);
      exp_rd.push_back(expect_word);
      reg_address_in = A_DSKDATR;
      tick();
      idle_bus();
   endtask

   task automatic pull_word(input logic [15:0] expect_word);
      exp_wr.push_back(expect_word);
      sh_pull = 1'b1;
      tick();
      idle_bus();
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic wait_blk(input string name);
      for (int i = 0; i < 8 && exp_blk.size() != 0; i++) begin
         tick();
      end
      n_vec++;
      if (exp_blk.size() != 0) begin
         n_err++;
         $display("FAIL %s: int_dskblk pulses seen=0, want 1", name);
         exp_blk.delete();
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data_out"}, data_out, 16'h0000);
      chk({tag, "_sh_dout"},  sh_dout, 16'h0000);
      chk({tag, "_flags"}, {10'd0, dmal, dmas, int_dskblk, busy, overrun, underrun}, 16'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b0;
      clk7_en  = 1'b1;
      dmaen    = 1'b1;
      wordsync = 1'b0;
      idle_bus();
      tick();
      tick();
      chk_all_zero("reset_held");
      reset_n = 1'b1;
      tick();
      chk_all_zero("reset_rel");

      // Read of three words, no sync
      bus_wr(A_DSKLEN, 16'h8003);
      chk("rd3_armed_busy", {15'd0, busy}, 16'd0);
      chk("rd3_armed_dmal", {15'd0, dmal}, 16'd0);
      bus_wr(A_DSKLEN, 16'h8003);
      chk("rd3_start_busy", {15'd0, busy}, 16'd1);
      chk("rd3_start_dmal", {15'd0, dmal}, 16'd0);
      push_word(16'h1111);
      push_word(16'h2222);
      push_word(16'h3333);
      chk("rd3_filled_dmal", {15'd0, dmal}, 16'd1);
      exp_blk.push_back(1);
      grant_rd(16'h1111);
      grant_rd(16'h2222);
      grant_rd(16'h3333);
      wait_blk("rd3_blk");
      chk("rd3_end_busy", {15'd0, busy}, 16'd0);

      // Write of two words
      bus_wr(A_DSKLEN, 16'hC002);
      bus_wr(A_DSKLEN, 16'hC002);
      chk("wr2_dmas", {15'd0, dmas}, 16'd1);
      chk("wr2_dmal_start", {15'd0, dmal}, 16'd1);
      bus_wr(A_DSKDAT, 16'hBEEF);
      bus_wr(A_DSKDAT, 16'hCAFE);
      chk("wr2_dmal_cnt0", {15'd0, dmal}, 16'd0);
      chk("wr2_busy", {15'd0, busy}, 16'd1);
      pull_word(16'hBEEF);
      exp_blk.push_back(2);
      pull_word(16'hCAFE);
      wait_blk("wr2_blk");
      chk("wr2_end_busy", {15'd0, busy}, 16'd0);
      chk("wr2_underrun", {15'd0, underrun}, 16'd0);

      // Overrun with len 8, five pushes, no grants
      bus_wr(A_DSKLEN, 16'h8008);
      bus_wr(A_DSKLEN, 16'h8008);
      push_word(16'hA001);
      push_word(16'hA002);
      push_word(16'hA003);
      push_word(16'hA004);
      chk("ovr_before", {15'd0, overrun}, 16'd0);
      push_word(16'hA005);
      chk("ovr_set", {15'd0, overrun}, 16'd1);
      chk("ovr_dmal", {15'd0, dmal}, 16'd1);
      dmaen = 1'b0;
      #1;
      chk("ovr_dmaen_off_dmal", {15'd0, dmal}, 16'd0);
      dmaen = 1'b1;
      grant_rd(16'hA001);
      grant_rd(16'hA002);
      grant_rd(16'hA003);
      grant_rd(16'hA004);
      grant_rd(16'h0000);
      chk("ovr_sticky", {15'd0, overrun}, 16'd1);
      bus_wr(A_DSKLEN, 16'h0000);
      chk("ovr_cleared", {15'd0, overrun}, 16'd0);
      chk("ovr_idle_busy", {15'd0, busy}, 16'd0);

      // Word sync: pushes before the sync word are dropped
      wordsync = 1'b1;
      bus_wr(A_DSKLEN, 16'h8002);
      bus_wr(A_DSKLEN, 16'h8002);
      chk("sync_wait_busy", {15'd0, busy}, 16'd1);
      push_word(16'hD001);
      push_word(16'hD002);
      sync_match = 1'b1;
      sh_push    = 1'b1;
      sh_word    = 16'h4489;
      tick();
      idle_bus();
      wordsync = 1'b0;
      chk("sync_fifo_empty_dmal", {15'd0, dmal}, 16'd0);
      push_word(16'hD003);
      push_word(16'hD004);
      chk("sync_dmal", {15'd0, dmal}, 16'd1);
      exp_blk.push_back(3);
      grant_rd(16'hD003);
      grant_rd(16'hD004);
      wait_blk("sync_blk");
      chk("sync_end_busy", {15'd0, busy}, 16'd0);

      // Abort mid-READ via DSKLEN=0 flushes the FIFO without an interrupt
      bus_wr(A_DSKLEN, 16'h8004);
      bus_wr(A_DSKLEN, 16'h8004);
      push_word(16'hF001);
      push_word(16'hF002);
      chk("abort_pre_dmal", {15'd0, dmal}, 16'd1);
      bus_wr(A_DSKLEN, 16'h0000);
      chk("abort_busy", {15'd0, busy}, 16'd0);
      chk("abort_dmal", {15'd0, dmal}, 16'd0);
      bus_wr(A_DSKLEN, 16'h8001);
      bus_wr(A_DSKLEN, 16'h8001);
      chk("abort_flushed_dmal", {15'd0, dmal}, 16'd0);
      bus_wr(A_DSKLEN, 16'h0000);
      tick();
      tick();

      // Underrun then asynchronous reset mid-WRITE
      bus_wr(A_DSKLEN, 16'hC003);
      bus_wr(A_DSKLEN, 16'hC003);
      bus_wr(A_DSKDAT, 16'h1234);
      chk("rst_wr_dmal", {15'd0, dmal}, 16'd1);
      pull_word(16'h1234);
      pull_word(16'hAAAA);
      tick();
      chk("rst_wr_underrun", {15'd0, underrun}, 16'd1);
      chk("rst_wr_dmas", {15'd0, dmas}, 16'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all_zero("rst_async");
      tick();
      reset_n = 1'b1;
      tick();

      // Zero-length block and simultaneous push/pop at level 2
      bus_wr(A_DSKLEN, 16'h8000);
      exp_blk.push_back(4);
      bus_wr(A_DSKLEN, 16'h8000);
      wait_blk("len0_blk");
      chk("len0_busy", {15'd0, busy}, 16'd0);
      bus_wr(A_DSKLEN, 16'h8004);
      bus_wr(A_DSKLEN, 16'h8004);
      push_word(16'hE001);
      push_word(16'hE002);
      exp_rd.push_back(16'hE001);
      sh_push        = 1'b1;
      sh_word        = 16'hE003;
      reg_address_in = A_DSKDATR;
      tick();
      idle_bus();
      exp_blk.push_back(5);
      grant_rd(16'hE002);
      grant_rd(16'hE003);
      grant_rd(16'h0000);
      wait_blk("pp_blk");
      chk("pp_end_busy", {15'd0, busy}, 16'd0);

      tick();
      chk("end_rd_queue", 16'(exp_rd.size()), 16'd0);
      chk("end_wr_queue", 16'(exp_wr.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
